turn_arbiter: RTL and testbench

- Sequences a two-party board game (player vs PC) and arbitrates the single board-write port between the player input path and the PC move generator.
- Enforces a per-turn countdown, hands each write to the external victory checker, and declares win/draw.
- Sits between the input/PC-move logic and the board memory/ALU.

---
 rtl/game_pkg.sv | 22 ++
 rtl/turn_timer.sv | 40 ++++
 rtl/turn_arbiter.sv | 172 +++++++++++++++++
 tb/tb_turn_arbiter.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared types for the turn arbiter: FSM states, winner codes and turn encoding.
package game_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_P_TURN,
    S_P_WRITE,
    S_PC_TURN,
    S_PC_WRITE,
    S_CHECK,
    S_OVER
  } state_t;

  localparam logic [1:0] WIN_NONE   = 2'b00;
  localparam logic [1:0] WIN_PLAYER = 2'b01;
  localparam logic [1:0] WIN_PC     = 2'b10;
  localparam logic [1:0] WIN_DRAW   = 2'b11;

  localparam logic TURN_PLAYER = 1'b0;
  localparam logic TURN_PC     = 1'b1;

endpackage

// File: rtl/turn_timer.sv
// Per-turn countdown: a TICK_DIV-cycle divider feeding a saturating 4-bit seconds counter.
module turn_timer #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_load,
  input  logic [3:0] i_load_secs,
  input  logic       i_en,
  output logic [3:0] o_secs_left,
  output logic       o_expired
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] r_tick;
  logic [3:0]    r_secs;

  // Load wins over counting so every turn entry starts from a clean tick phase.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tick <= '0;
      r_secs <= '0;
    end else if (i_load) begin
      r_tick <= '0;
      r_secs <= i_load_secs;
    end else if (i_en) begin
      if (r_tick == CW'(TICK_DIV - 1)) begin
        r_tick <= '0;
        if (r_secs != 4'd0) r_secs <= r_secs - 4'd1;
      end else begin
        r_tick <= r_tick + CW'(1);
      end
    end
  end

  assign o_secs_left = r_secs;
  assign o_expired   = (r_secs == 4'd0);

endmodule

// File: rtl/turn_arbiter.sv
// Player-vs-PC game sequencer owning the single board-write port; rst is async active-low.
// Define PC_TIMEOUT_EN to time the PC turn like the player turn.
//   state      | meaning
//   S_IDLE     | after reset, waiting for start
//   S_P_TURN   | timed player turn, waiting for p_req
//   S_P_WRITE  | one-cycle player board write
//   S_PC_TURN  | PC turn, waiting for pc_req
//   S_PC_WRITE | one-cycle PC board write
//   S_CHECK    | waiting for victory checker result
//   S_OVER     | game finished, winner held until start
module turn_arbiter
  import game_pkg::*;
#(
  parameter int TICK_DIV  = 50_000_000,
  parameter int TURN_SECS = 15,
  parameter int MAX_MOVES = 9,
  parameter int ADDR_W    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              p_req,
  input  logic [ADDR_W-1:0] p_addr,
  output logic              p_gnt,
  input  logic              pc_req,
  input  logic [ADDR_W-1:0] pc_addr,
  output logic              pc_gnt,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              wr_who,
  input  logic              chk_done,
  input  logic              chk_win,
  output logic              turn,
  output logic [3:0]        secs_left,
  output logic              timeout,
  output logic              game_over,
  output logic [1:0]        winner
);

  state_t            r_state;
  logic [3:0]        r_moves;
  logic              r_p_gnt, r_pc_gnt, r_wr_en, r_wr_who, r_turn, r_timeout, r_game_over;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [1:0]        r_winner;

  logic       w_expired, w_start, w_chk_next, w_board_full;
  logic       w_p_expire, w_pc_expire, w_to_p, w_to_pc, w_tmr_en;
  logic [3:0] w_secs, w_load_secs;

`ifdef PC_TIMEOUT_EN
  localparam logic [3:0] PC_SECS = 4'(TURN_SECS);
  assign w_pc_expire = (r_state == S_PC_TURN) && w_expired && !pc_req;
  assign w_tmr_en    = (r_state == S_P_TURN) || (r_state == S_PC_TURN);
`else
  localparam logic [3:0] PC_SECS = 4'd0;
  assign w_pc_expire = 1'b0;
  assign w_tmr_en    = (r_state == S_P_TURN);
`endif

  assign w_board_full = (r_moves == 4'(MAX_MOVES));
  assign w_start      = ((r_state == S_IDLE) || (r_state == S_OVER)) && start;
  assign w_chk_next   = (r_state == S_CHECK) && chk_done && !chk_win && !w_board_full;
  assign w_p_expire   = (r_state == S_P_TURN) && w_expired && !p_req;
  // Timer reload mirrors every FSM edge that enters a turn state.
  assign w_to_p       = w_start || (w_chk_next && (r_wr_who == TURN_PC)) || w_pc_expire;
  assign w_to_pc      = (w_chk_next && (r_wr_who == TURN_PLAYER)) || w_p_expire;
  assign w_load_secs  = w_to_p ? 4'(TURN_SECS) : PC_SECS;

  turn_timer #(.TICK_DIV(TICK_DIV)) u_timer (
    .clk         (clk),
    .rst         (rst),
    .i_load      (w_to_p || w_to_pc),
    .i_load_secs (w_load_secs),
    .i_en        (w_tmr_en),
    .o_secs_left (w_secs),
    .o_expired   (w_expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_moves     <= '0;
      r_p_gnt     <= 1'b0;
      r_pc_gnt    <= 1'b0;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_who    <= 1'b0;
      r_turn      <= TURN_PLAYER;
      r_timeout   <= 1'b0;
      r_game_over <= 1'b0;
      r_winner    <= WIN_NONE;
    end else begin
      r_p_gnt   <= 1'b0;
      r_pc_gnt  <= 1'b0;
      r_wr_en   <= 1'b0;
      r_timeout <= 1'b0;
      case (r_state)
        S_IDLE, S_OVER: begin
          if (start) begin
            r_state     <= S_P_TURN;
            r_turn      <= TURN_PLAYER;
            r_moves     <= '0;
            r_winner    <= WIN_NONE;
            r_game_over <= 1'b0;
          end
        end
        S_P_TURN: begin
          if (p_req) begin
            r_state   <= S_P_WRITE;
            r_wr_addr <= p_addr;
            r_wr_who  <= TURN_PLAYER;
            r_p_gnt   <= 1'b1;
            r_wr_en   <= 1'b1;
          end else if (w_expired) begin
            r_state   <= S_PC_TURN;
            r_turn    <= TURN_PC;
            r_timeout <= 1'b1;
          end
        end
        S_PC_TURN: begin
          if (pc_req) begin
            r_state   <= S_PC_WRITE;
            r_wr_addr <= pc_addr;
            r_wr_who  <= TURN_PC;
            r_pc_gnt  <= 1'b1;
            r_wr_en   <= 1'b1;
          end else if (w_pc_expire) begin
            r_state   <= S_P_TURN;
            r_turn    <= TURN_PLAYER;
            r_timeout <= 1'b1;
          end
        end
        S_P_WRITE, S_PC_WRITE: begin
          r_moves <= r_moves + 4'd1;
          r_state <= S_CHECK;
        end
        S_CHECK: begin
          if (chk_done) begin
            if (chk_win) begin
              r_state     <= S_OVER;
              r_game_over <= 1'b1;
              r_winner    <= (r_wr_who == TURN_PC) ? WIN_PC : WIN_PLAYER;
            end else if (w_board_full) begin
              r_state     <= S_OVER;
              r_game_over <= 1'b1;
              r_winner    <= WIN_DRAW;
            end else if (r_wr_who == TURN_PLAYER) begin
              r_state <= S_PC_TURN;
              r_turn  <= TURN_PC;
            end else begin
              r_state <= S_P_TURN;
              r_turn  <= TURN_PLAYER;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign p_gnt     = r_p_gnt;
  assign pc_gnt    = r_pc_gnt;
  assign wr_en     = r_wr_en;
  assign wr_addr   = r_wr_addr;
  assign wr_who    = r_wr_who;
  assign turn      = r_turn;
  assign secs_left = w_secs;
  assign timeout   = r_timeout;
  assign game_over = r_game_over;
  assign winner    = r_winner;

endmodule

// File: tb/tb_turn_arbiter.sv
// Randomized bench for turn_arbiter against a game-level reference model.
module tb_turn_arbiter;

  localparam int TICK_DIV  = 4;
  localparam int TURN_SECS = 3;
  localparam int MAX_MOVES = 9;
  localparam int EXP_K     = TURN_SECS * TICK_DIV;

  logic clk = 1'b0, rst = 1'b0, start = 1'b0;
  logic p_req = 1'b0, pc_req = 1'b0, chk_done = 1'b0, chk_win = 1'b0;
  logic [3:0] p_addr = '0, pc_addr = '0;
  logic p_gnt, pc_gnt, wr_en, wr_who, turn, timeout, game_over;
  logic [3:0] wr_addr, secs_left;
  logic [1:0] winner;

  int n_checks = 0;
  int n_pass   = 0;

  turn_arbiter #(.TICK_DIV(TICK_DIV), .TURN_SECS(TURN_SECS), .MAX_MOVES(MAX_MOVES), .ADDR_W(4)) dut (
    .clk(clk), .rst(rst), .start(start),
    .p_req(p_req), .p_addr(p_addr), .p_gnt(p_gnt),
    .pc_req(pc_req), .pc_addr(pc_addr), .pc_gnt(pc_gnt),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_who(wr_who),
    .chk_done(chk_done), .chk_win(chk_win),
    .turn(turn), .secs_left(secs_left), .timeout(timeout),
    .game_over(game_over), .winner(winner)
  );

  always #5 clk = ~clk;

  // Seconds remaining k cycles after entering a timed turn.
  function automatic logic [3:0] exp_secs(input int k);
    int s;
    s = TURN_SECS - k / TICK_DIV;
    return (s < 0) ? 4'd0 : 4'(s);
  endfunction

  function automatic logic [3:0] exp_pc_secs(input int k);
`ifdef PC_TIMEOUT_EN
    return exp_secs(k);
`else
    return (k >= 0) ? 4'd0 : 4'd0;
`endif
  endfunction

  task automatic do_reset();
    rst = 1'b0; start = 0; p_req = 0; pc_req = 0; chk_done = 0; chk_win = 0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if ({turn, secs_left, game_over, winner} !== {1'b0, 4'(TURN_SECS), 1'b0, 2'b00})
      $display("FAIL start_state got turn=%b secs=%0d go=%b win=%b exp 0/%0d/0/00", turn, secs_left, game_over, winner, TURN_SECS);
    else n_pass++;
  endtask

  // Player turn: request after d cycles; d > EXP_K means let it expire.
  task automatic player_turn(input int d, input logic [3:0] a, output bit wrote);
    wrote = 1'b0;
    for (int k = 0; k <= EXP_K + 1; k++) begin
      if (k == EXP_K + 1) begin
        n_checks++;
        if ({timeout, turn, wr_en, p_gnt} !== 4'b1100)
          $display("FAIL p_timeout got to=%b turn=%b wr=%b pg=%b exp 1100", timeout, turn, wr_en, p_gnt);
        else n_pass++;
        pc_req = 1'b0;
        return;
      end
      n_checks++;
      if ({secs_left, turn, wr_en, p_gnt, pc_gnt, (k > 0) && timeout} !== {exp_secs(k), 5'b00000})
        $display("FAIL p_turn k=%0d got secs=%0d turn=%b wr=%b pg=%b pcg=%b to=%b exp secs=%0d rest 0",
                 k, secs_left, turn, wr_en, p_gnt, pc_gnt, timeout, exp_secs(k));
      else n_pass++;
      pc_req = 1'($urandom_range(1, 0));
      if (k == d) begin
        p_req = 1'b1; p_addr = a;
        @(negedge clk);
        p_req = 1'b0; pc_req = 1'b0;
        n_checks++;
        if ({p_gnt, pc_gnt, wr_en, wr_addr, wr_who, timeout} !== {1'b1, 1'b0, 1'b1, a, 1'b0, 1'b0})
          $display("FAIL p_grant got pg=%b pcg=%b wr=%b addr=%0d who=%b to=%b exp 1 0 1 %0d 0 0",
                   p_gnt, pc_gnt, wr_en, wr_addr, wr_who, timeout, a);
        else n_pass++;
        wrote = 1'b1;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic pc_turn(input int d, input logic [3:0] a);
    for (int k = 0; k <= d; k++) begin
      n_checks++;
      if ({secs_left, turn, wr_en, p_gnt, pc_gnt} !== {exp_pc_secs(k), 4'b1000})
        $display("FAIL pc_turn k=%0d got secs=%0d turn=%b wr=%b pg=%b pcg=%b exp secs=%0d 1000",
                 k, secs_left, turn, wr_en, p_gnt, pc_gnt, exp_pc_secs(k));
      else n_pass++;
      p_req = 1'($urandom_range(1, 0));
      if (k == d) begin
        pc_req = 1'b1; pc_addr = a;
      end
      @(negedge clk);
    end
    pc_req = 1'b0; p_req = 1'b0;
    n_checks++;
    if ({pc_gnt, p_gnt, wr_en, wr_addr, wr_who} !== {1'b1, 1'b0, 1'b1, a, 1'b1})
      $display("FAIL pc_grant got pcg=%b pg=%b wr=%b addr=%0d who=%b exp 1 0 1 %0d 1",
               pc_gnt, p_gnt, wr_en, wr_addr, wr_who, a);
    else n_pass++;
  endtask

  // Entered at the write-cycle sample; leaves at the sample after the checker responds.
  task automatic check_phase(input int c, input bit win);
    @(negedge clk);
    for (int j = 0; j <= c; j++) begin
      n_checks++;
      if ({wr_en, p_gnt, pc_gnt, game_over} !== 4'b0000)
        $display("FAIL check_wait j=%0d got wr=%b pg=%b pcg=%b go=%b exp 0000", j, wr_en, p_gnt, pc_gnt, game_over);
      else n_pass++;
      if (j == c) begin
        chk_done = 1'b1; chk_win = win;
      end
      @(negedge clk);
    end
    chk_done = 1'b0; chk_win = 1'b0;
  endtask

  task automatic play_game(input int win_pct, input int pmax);
    int  moves, who;
    bit  over, wrote, win;
    logic [1:0] expw;
    do_start();
    moves = 0; who = 0; over = 1'b0; expw = 2'b00;
    for (int it = 0; it < 40 && !over; it++) begin
      if (who == 0) begin
        player_turn($urandom_range(pmax, 0), 4'($urandom_range(15, 0)), wrote);
      end else begin
        pc_turn($urandom_range(5, 0), 4'($urandom_range(15, 0)));
        wrote = 1'b1;
      end
      if (!wrote) begin
        who = 1;
        continue;
      end
      win = ($urandom_range(99, 0) < win_pct);
      check_phase($urandom_range(3, 0), win);
      moves++;
      if (win) begin
        over = 1'b1; expw = (who == 1) ? 2'b10 : 2'b01;
      end else if (moves == MAX_MOVES) begin
        over = 1'b1; expw = 2'b11;
      end else begin
        who = 1 - who;
      end
    end
    n_checks++;
    if (!over) $display("FAIL game_bound got no end after 40 turns exp end");
    else n_pass++;
    for (int h = 0; h < 3; h++) begin
      n_checks++;
      if ({game_over, winner, wr_en} !== {1'b1, expw, 1'b0})
        $display("FAIL game_end h=%0d moves=%0d got go=%b win=%b wr=%b exp 1 %b 0", h, moves, game_over, winner, wr_en, expw);
      else n_pass++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({p_gnt, pc_gnt, wr_en, wr_addr, wr_who, turn, secs_left, timeout, game_over, winner} !== 17'd0)
      $display("FAIL reset_outputs got nonzero output exp all 0");
    else n_pass++;
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_win();
    bit wrote;
    do_start();
    player_turn(2, 4'd5, wrote);
    check_phase(1, 1'b1);
    n_checks++;
    if ({game_over, winner} !== 3'b101)
      $display("FAIL player_win got go=%b win=%b exp 1 01", game_over, winner);
    else n_pass++;
    do_start();
  endtask

  task automatic test_timeout();
    bit wrote;
    do_reset();
    do_start();
    player_turn(99, 4'd0, wrote);
    n_checks++;
    if (wrote !== 1'b0) $display("FAIL timeout_nowrite got wrote=%b exp 0", wrote);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({timeout, turn, wr_en} !== 3'b010)
      $display("FAIL timeout_pulse got to=%b turn=%b wr=%b exp 010", timeout, turn, wr_en);
    else n_pass++;
  endtask

  task automatic test_expiry_and_reset();
    bit wrote;
    do_reset();
    do_start();
    player_turn(EXP_K, 4'd7, wrote);
    #1 rst = 1'b0;
    #1;
    n_checks++;
    if ({p_gnt, pc_gnt, wr_en, wr_addr, wr_who, turn, secs_left, timeout, game_over, winner} !== 17'd0)
      $display("FAIL reset_mid_write got wr=%b addr=%0d exp all 0", wr_en, wr_addr);
    else n_pass++;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    play_game(0, 12);
  endtask

  task automatic test_pc_idle();
    bit wrote;
    do_reset();
    do_start();
    player_turn(1, 4'd3, wrote);
    check_phase(0, 1'b0);
    for (int k = 0; k < 100; k++) begin
`ifdef PC_TIMEOUT_EN
      if (k == EXP_K + 1) begin
        n_checks++;
        if ({timeout, turn, secs_left} !== {1'b1, 1'b0, 4'(TURN_SECS)})
          $display("FAIL pc_timeout got to=%b turn=%b secs=%0d exp 1 0 %0d", timeout, turn, secs_left, TURN_SECS);
        else n_pass++;
        break;
      end
`endif
      n_checks++;
      if ({secs_left, turn, pc_gnt, p_gnt, wr_en, timeout} !== {exp_pc_secs(k), 5'b10000})
        $display("FAIL pc_idle k=%0d got secs=%0d turn=%b pcg=%b pg=%b wr=%b to=%b exp %0d 10000",
                 k, secs_left, turn, pc_gnt, p_gnt, wr_en, timeout, exp_pc_secs(k));
      else n_pass++;
      p_req = 1'($urandom_range(1, 0));
      @(negedge clk);
    end
    p_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_win();
    test_timeout();
    test_expiry_and_reset();
    test_pc_idle();
    do_reset();
    play_game(0, 12);
    for (int g = 0; g < 6; g++) play_game(20, 15);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
